tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//  Receive side of the 4-lane TDM link. A 4:1 slot mux serialises lanes I[0..3] one slot per beat.
//  This block rebuilds the frame: it tracks the slot index, captures each beat into its lane register,
//  and presents the whole frame in parallel with a one-cycle valid pulse. It also tracks frame
//  alignment from the start-of-frame marker and reports alignment errors and a lock status.
// PARAMETERS
//  DATA_W       1  width of one lane beat in bits
//  NUM_LANES    4  slots per frame; slot k carries lane k, matching mux select {S1,S0}=k
//  LOCK_FRAMES  2  consecutive good frames needed before locked asserts
// PORTS
//  clk        in   1                  rising-edge clock for all state
//  rst        in   1                  synchronous, active-high reset
//  din_valid  in   1                  din/sof carry a slot beat this cycle
//  din        in   DATA_W             serial slot data
//  sof        in   1                  start-of-frame marker; qualified by din_valid; marks slot 0
//  sel        out  $clog2(NUM_LANES)  slot index the next valid beat is written to
//  out_data   out  NUM_LANES*DATA_W   frame; lane k at [k*DATA_W +: DATA_W]
//  out_valid  out  1                  one-cycle pulse: out_data holds a new complete frame
//  frame_err  out  1                  one-cycle pulse: alignment violation detected
//  locked     out  1                  level: LOCK_FRAMES consecutive good frames seen
// BEHAVIOUR
//  Reset: state=HUNT, sel=0, lane regs=0, out_data=0, out_valid=0, frame_err=0, locked=0, good_cnt=0.
//   rst wins over every other input in the same cycle.
//   Reset mid-frame drops the partial frame. No out_valid pulse is emitted for it.
//  Cycles with din_valid=0: no state change, sel holds, no timeout. out_valid/frame_err return to 0.
//  HUNT:
//   - Valid beat with sof=1: capture din into lane 0, set sel=1, go to RUN.
//   - Valid beat with sof=0: discard the beat, stay in HUNT, frame_err stays 0.
//  RUN, valid beat at sel=k (k>0), sof=0:
//   - Capture din into lane k.
//   - sel = k+1, wrapping to 0 after NUM_LANES-1.
//  RUN, valid beat at sel=NUM_LANES-1:
//   - Next cycle: out_data = all lanes, out_valid=1.
//   - good_cnt saturates at LOCK_FRAMES; locked=1 once good_cnt reaches LOCK_FRAMES.
//  Latency: out_valid asserts 1 cycle after the clock edge that captures the last-slot beat.
//   out_data holds between pulses.
//  RUN, valid beat at sel=0, sof=1: normal start of the next frame; capture into lane 0, sel=1.
//  RUN, valid beat at sel=0, sof=0 (missing marker):
//   - frame_err=1 next cycle; drop the beat.
//   - Go to HUNT; locked=0, good_cnt=0.
//  RUN, valid beat at sel=k>0, sof=1 (early marker):
//   - frame_err=1 next cycle; drop the partial frame, no out_valid.
//   - Treat the beat as slot 0 of a new frame: capture into lane 0, sel=1, stay in RUN.
//   - locked=0, good_cnt=0.
//  out_valid and frame_err never both assert in the same cycle.
//  The lane written at slot k is exactly the lane the transmit mux selected with {S1,S0}=k.
// STRUCTURE
//  Package tdm_pkg:
//   - state enum {HUNT, RUN}
//   - SLOT_W = $clog2(NUM_LANES)
//   - lane-slice helper: lane k -> [k*DATA_W +: DATA_W]
//  Sub-module tdm_slot_counter: modulo-NUM_LANES counter with inputs clk, rst, inc, load0, load1.
//   Drives sel and a last_slot flag.
//  Top level: FSM, lane write-enable decode, shadow output register, good_cnt/lock logic.
// TESTING (DATA_W=1, NUM_LANES=4, LOCK_FRAMES=2)
//  1. Reset, then frames beats 1,0,1,0 (sof on beat 0), back-to-back:
//     -> out_data=4'b0101, out_valid pulse every 4 cycles;
//     -> locked=1 one cycle after the 2nd out_valid.
//  2. Beats sent with din_valid=0 gaps of 0..3 cycles -> same out_data, sel frozen during gaps.
//  3. Locked, then sof=1 on slot 2 -> frame_err pulse, no out_valid for that frame, locked=0.
//     -> Following 4 beats 0,1,1,0 give out_data=4'b0110.
//  4. Locked, then a slot-0 beat with sof=0 -> frame_err pulse, state HUNT.
//     -> Later beats with sof=0 are ignored until sof=1 arrives.
//  5. rst asserted after slot 2 of a frame -> all outputs 0 the next cycle, sel=0.
//     -> No out_valid pulse; the next frame is decoded correctly.
//  6. Loopback: a 4:1 mux driven by a free-running 2-bit counter, I=4'b1100, sof when the counter is 0
//     -> out_data=4'b1100 each frame, locked=1, frame_err never pulses.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the 4-lane TDM receive path.
package tdm_pkg;

  localparam int DEF_DATA_W      = 1;
  localparam int DEF_NUM_LANES   = 4;
  localparam int DEF_LOCK_FRAMES = 2;
  localparam int SLOT_W          = $clog2(DEF_NUM_LANES);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Lane k occupies bits [k*w +: w] of a flattened frame.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NUM_LANES slot counter; sel is the slot the next valid beat lands in.
// Zero-cycle decode of last_slot; advances only on inc/load, so idle cycles freeze it.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int SW        = $clog2(DEF_NUM_LANES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          load0,
  input  logic          load1,
  output logic [SW-1:0] sel,
  output logic          last_slot
);

  assign last_slot = (sel == SW'(NUM_LANES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0;
    end else if (load0) begin
      sel <= '0;
    end else if (load1) begin
      sel <= SW'(1);
    end else if (inc) begin
      sel <= last_slot ? '0 : sel + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// TDM frame rebuilder: slot tracking, lane capture, SOF alignment and lock status.
// out_valid/frame_err pulse one cycle after the deciding beat; no backpressure, din_valid=0 stalls.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_valid,
  input  logic [DATA_W-1:0]             din,
  input  logic                          sof,
  output logic [$clog2(NUM_LANES)-1:0]  sel,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic                          out_valid,
  output logic                          frame_err,
  output logic                          locked
);

  localparam int SW = $clog2(NUM_LANES);
  localparam int CW = $clog2(LOCK_FRAMES + 1);
  localparam int FW = NUM_LANES * DATA_W;

  state_t          state;
  logic [FW-1:0]   lanes;
  logic [FW-1:0]   lanes_nxt;
  logic [CW-1:0]   good_cnt;
  logic [SW-1:0]   wr_lane;
  logic            last_slot;
  logic            inc;
  logic            load0;
  logic            load1;
  logic            wr_en;
  logic            err;
  logic            done;
  logic            to_run;
  logic            to_hunt;

  tdm_slot_counter #(
    .NUM_LANES (NUM_LANES),
    .SW        (SW)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .load0     (load0),
    .load1     (load1),
    .sel       (sel),
    .last_slot (last_slot)
  );

  always_comb begin
    inc     = 1'b0;
    load0   = 1'b0;
    load1   = 1'b0;
    wr_en   = 1'b0;
    err     = 1'b0;
    done    = 1'b0;
    to_run  = 1'b0;
    to_hunt = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (sof) begin
            load1  = 1'b1;
            wr_en  = 1'b1;
            to_run = 1'b1;
          end
        end
        RUN: begin
          if (sof) begin
            // A marker anywhere restarts the frame at lane 0; off slot 0 it is an error.
            load1 = 1'b1;
            wr_en = 1'b1;
            err   = (sel != '0);
          end else if (sel == '0) begin
            err     = 1'b1;
            load0   = 1'b1;
            to_hunt = 1'b1;
          end else begin
            wr_en = 1'b1;
            inc   = 1'b1;
            done  = last_slot;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_lane   = load1 ? '0 : sel;
    lanes_nxt = lanes;
    if (wr_en) begin
      lanes_nxt[lane_lo(int'(wr_lane), DATA_W) +: DATA_W] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      lanes     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      good_cnt  <= '0;
      locked    <= 1'b0;
    end else begin
      out_valid <= done;
      frame_err <= err;
      lanes     <= lanes_nxt;
      if (done) begin
        out_data <= lanes_nxt;
      end
      if (to_run) begin
        state <= RUN;
      end else if (to_hunt) begin
        state <= HUNT;
      end
      if (err) begin
        good_cnt <= '0;
      end else if (done && (good_cnt != CW'(LOCK_FRAMES))) begin
        good_cnt <= good_cnt + CW'(1);
      end
      // Lock follows the registered count, so it rises the cycle after the qualifying pulse.
      locked <= err ? 1'b0 : (good_cnt == CW'(LOCK_FRAMES));
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 against a frame-level reference model.
module tb_tdm_demux4;

  localparam int NL = 4;
  localparam int LF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic [0:0] din = 1'b0;
  logic       sof = 1'b0;
  logic [1:0] sel;
  logic [3:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       locked;

  always #5 clk = ~clk;

  tdm_demux4 #(.DATA_W(1), .NUM_LANES(NL), .LOCK_FRAMES(LF)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .sof       (sof),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .locked    (locked)
  );

  typedef struct packed {
    logic       is_err;
    logic [3:0] data;
    logic       lock;
  } ev_t;

  ev_t expq[$];
  ev_t mon_ev;
  int  errors = 0;
  int  checks = 0;

  // Reference model: frame under construction, hunting flag, consecutive good frames.
  bit         m_hunt = 1'b1;
  int         m_idx = 0;
  logic [3:0] m_frame = 4'h0;
  int         m_good = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_sel();
    return m_hunt ? 32'd0 : 32'(m_idx);
  endfunction

  task automatic model_beat(input logic d, input logic s);
    if (m_hunt) begin
      if (s) begin
        m_frame[0] = d;
        m_idx      = 1;
        m_hunt     = 1'b0;
      end
    end else if (s) begin
      if (m_idx != 0) begin
        expq.push_back('{1'b1, 4'h0, 1'b0});
        m_good = 0;
      end
      m_frame[0] = d;
      m_idx      = 1;
    end else if (m_idx == 0) begin
      expq.push_back('{1'b1, 4'h0, 1'b0});
      m_good = 0;
      m_hunt = 1'b1;
    end else begin
      m_frame[m_idx] = d;
      m_idx++;
      if (m_idx == NL) begin
        expq.push_back('{1'b0, m_frame, (m_good >= LF)});
        if (m_good < LF) m_good++;
        m_idx = 0;
      end
    end
  endtask

  task automatic beat(input logic d, input logic s);
    @(negedge clk);
    check("sel_before_beat", 32'(sel), exp_sel());
    din_valid = 1'b1;
    din       = d;
    sof       = s;
    model_beat(d, s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("sel_idle", 32'(sel), exp_sel());
      din_valid = 1'b0;
      din       = 1'($urandom);
      sof       = 1'($urandom);
    end
  endtask

  task automatic send_frame(input logic [3:0] bits, input int max_gap);
    for (int k = 0; k < NL; k++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      beat(bits[k], k == 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'($urandom);
    din       = 1'($urandom);
    sof       = 1'($urandom);
    @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    rst       = 1'b0;
    din_valid = 1'b0;
    m_hunt    = 1'b1;
    m_idx     = 0;
    m_good    = 0;
  endtask

  always @(negedge clk) begin
    if (out_valid || frame_err) begin
      check("pulse_exclusive", 32'(out_valid & frame_err), 32'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: out_valid=%0b frame_err=%0b expected no pulse at %0t",
                 out_valid, frame_err, $time);
      end else begin
        mon_ev = expq.pop_front();
        check("pulse_kind_err", 32'(frame_err), 32'(mon_ev.is_err));
        if (!mon_ev.is_err) check("out_data", 32'(out_data), 32'(mon_ev.data));
        check("locked_at_pulse", 32'(locked), 32'(mon_ev.lock));
      end
    end
  end

  logic [3:0] lb_i;
  logic [1:0] lb_cnt;

  initial begin
    do_reset();

    // Back-to-back frames 1,0,1,0 -> 4'b0101, lock after the second frame.
    for (int f = 0; f < 3; f++) send_frame(4'b0101, 0);
    idle(2);
    check("lock_after_frames", 32'(locked), 32'(m_good >= LF));

    // Idle gaps between beats.
    for (int f = 0; f < 3; f++) send_frame(4'b0101, 3);

    // Early marker on slot 2, then 0,1,1,0 forms the new frame.
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    idle(2);
    check("lock_after_early_sof", 32'(locked), 32'(m_good >= LF));

    // Missing marker at slot 0 -> hunt, stray beats ignored until sof.
    send_frame(4'b1001, 0);
    send_frame(4'b1001, 0);
    beat(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) beat(1'($urandom), 1'b0);
    send_frame(4'b1100, 1);
    idle(2);
    check("lock_after_hunt", 32'(locked), 32'(m_good >= LF));

    // Reset after slot 2 drops the partial frame.
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    do_reset();
    send_frame(4'b1011, 0);
    idle(2);

    // Loopback of a free-running 4:1 mux carrying I=4'b1100.
    do_reset();
    lb_i   = 4'b1100;
    lb_cnt = 2'($urandom);
    for (int i = 0; i < 40; i++) begin
      beat(lb_i[lb_cnt], lb_cnt == 2'd0);
      lb_cnt = lb_cnt + 2'd1;
    end
    idle(2);
    check("loopback_locked", 32'(locked), 32'd1);

    // Random traffic with occasional misplaced markers.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      beat(1'($urandom), (exp_sel() == 32'd0) ^ ($urandom_range(0, 15) == 0));
    end
    idle(3);
    check("queue_drained", 32'(expq.size()), 32'd0);
    check("final_locked", 32'(locked), 32'(m_good >= LF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
